mmio_uart_tx: RTL

Memory-mapped console transmitter that sits on the CPU data bus in `main` and responds to the MMIO stores the CPU issues to the `addr[31]=1` region. Console bytes are queued in a small FIFO and serialised as 8N1 UART frames on a pin, so the same program prints on an FPGA board as in simulation. The block also decodes the end-of-program store and asserts a registered finish flag.

---
 rtl/mmio_uart_tx.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped console transmitter.
//
// Sits on the CPU data bus and decodes stores/loads to the addr[31]=1
// region. Bytes written to TXDATA are queued in a small FIFO and sent as
// 8N1 UART frames on txd_o. STATUS reports busy/full/overflow and the FIFO
// fill level.
//
// Register map (addr_i[31]=1, index = addr_i[3:2]):
//   0 TXDATA (write): wdata_i[7:0] is queued.
//   1 STATUS (read) : [0] busy, [1] full, [2] ovf (cleared by the read),
//                     [15:8] FIFO count.
//   2,3             : writes ignored, reads return 0.
//
// Optional feature, macro MMIO_UART_FINI_EN:
//   defined   -> a TXDATA store of 32'h00020000 sets the sticky fini_o flag
//                and is not queued.
//   undefined -> fini_o is tied low and that store queues byte 8'h00.
//
// Ports:
//   clk_i     clock (single domain)
//   rst       synchronous active-high reset
//   wvalid_i  store strobe
//   rden_i    load strobe
//   addr_i    bus address
//   wdata_i   store data
//   rdata_o   registered load data, held until the next load
//   txd_o     UART serial output, idles high
//   fini_o    sticky end-of-program flag
//
// Parameters:
//   BAUD_DIV    clock cycles per UART bit (>= 2)
//   FIFO_DEPTH  FIFO entries (power of two, >= 2)

module mmio_uart_tx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        wvalid_i,
  input  logic        rden_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        txd_o,
  output logic        fini_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------- state
  state_t            state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg,  baud_next;
  logic [2:0]        bit_reg,   bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              txd_reg,   txd_next;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [7:0]        head_reg;
  logic [PTR_W-1:0]  wptr_reg, rptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              ovf_reg;
  logic [31:0]       rdata_reg;

  // ---------------------------------------------------------------- decode
  logic sel;
  logic wr_tx;
  logic rd_status;
  logic is_fini;
  logic enq;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;
  logic busy;
  logic [7:0]  count_byte;
  logic [31:0] status_word;

  assign sel       = addr_i[31];
  assign wr_tx     = wvalid_i & sel & (addr_i[3:2] == 2'd0);
  assign rd_status = rden_i & sel & (addr_i[3:2] == 2'd1);

`ifdef MMIO_UART_FINI_EN
  localparam logic [31:0] FINI_CODE = 32'h0002_0000;
  assign is_fini = wr_tx & (wdata_i == FINI_CODE);
`else
  assign is_fini = 1'b0;
`endif

  assign enq        = wr_tx & ~is_fini;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_FULL);
  // The FSM takes the head whenever it is idle and data is waiting.
  assign pop        = (state_reg == ST_IDLE) & ~fifo_empty;
  // A full FIFO still has room if the head leaves in the same cycle.
  assign push       = enq & (~fifo_full | pop);
  assign drop       = enq & fifo_full & ~pop;

  assign busy        = ~fifo_empty | (state_reg != ST_IDLE);
  assign count_byte  = 8'(count_reg);
  assign status_word = {16'h0000, count_byte, 5'b00000, ovf_reg, fifo_full, busy};

  // Address/data bits that the register map does not look at.
  logic unused_bits;
  assign unused_bits = &{1'b0, addr_i[30:4], addr_i[1:0], wdata_i[31:8]};

  // ---------------------------------------------------------------- FIFO
  // Storage has no reset so it maps onto block RAM. The head is read into
  // head_reg on the pop edge; a same-edge write to the same slot (full FIFO
  // refilled during a pop) sees the old contents, which is the correct head.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wptr_reg] <= wdata_i[7:0];
    end
    if (pop) begin
      head_reg <= fifo_mem[rptr_reg];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    txd_next   = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (pop) begin
          state_next = ST_START;
          baud_next  = BAUD_RELOAD;
          bit_next   = 3'd0;
        end
      end
      ST_START: begin
        if (baud_reg == '0) begin
          // head_reg was loaded on the pop edge, well before this point.
          state_next = ST_DATA;
          baud_next  = BAUD_RELOAD;
          bit_next   = 3'd0;
          shift_next = head_reg;
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_reg == '0) begin
          baud_next = BAUD_RELOAD;
          if (bit_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_next   = bit_reg + 3'd1;
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          baud_next = baud_reg - BAUD_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // The pin is registered from the next state so it never glitches.
    case (state_next)
      ST_START: txd_next = 1'b0;
      ST_DATA:  txd_next = shift_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- STATUS
  // ovf set wins over the read-clear so a drop in the read cycle is kept.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      ovf_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (rd_status) begin
        ovf_reg <= 1'b0;
      end
      if (rden_i) begin
        rdata_reg <= rd_status ? status_word : 32'h0000_0000;
      end
    end
  end

  // ---------------------------------------------------------------- finish
`ifdef MMIO_UART_FINI_EN
  logic fini_reg;
  always_ff @(posedge clk_i) begin
    if (rst) begin
      fini_reg <= 1'b0;
    end else if (is_fini) begin
      fini_reg <= 1'b1;
    end
  end
  assign fini_o = fini_reg;
`else
  assign fini_o = 1'b0;
`endif

  assign rdata_o = rdata_reg;
  assign txd_o   = txd_reg;

endmodule
